// File: rtl/req_client_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : req_client_pkg
//  Description : Shared types and width helpers for the req_client requester.
//  Revision    : 1.0 - initial release
// ============================================================================
package req_client_pkg;

   localparam int NCHAN = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      OWN  = 2'd2,
      GAP  = 2'd3
   } chan_state_t;

   // Tenure counter holds TENURE-1 down to 0; keep at least one bit.
   function automatic int ten_w(input int tenure);
      return (tenure > 1) ? $clog2(tenure) : 1;
   endfunction

   // Wait counter must be able to hold the value TIMEOUT itself.
   function automatic int wait_w(input int timeout);
      return (timeout > 0) ? $clog2(timeout + 1) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/req_client_chan.sv
`default_nettype none
// ============================================================================
//  Module      : req_client_chan
//  Description : One requester channel: pending counter, IDLE/REQ/OWN/GAP
//                FSM with fixed ownership tenure, optional grant watchdog.
//                Watchdog compiled in with REQ_CLIENT_WATCHDOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module req_client_chan
   import req_client_pkg::*;
#(
   parameter int PEND_W  = 3,
   parameter int TENURE  = 4,
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic i_push,
   input  logic i_gnt,
   output logic o_req,
   output logic o_full,
   output logic o_done,
   output logic o_spur,
   output logic o_timeout
);

   localparam int                 TEN_W    = ten_w(TENURE);
   localparam logic [PEND_W-1:0]  PEND_MAX = '1;
   localparam logic [TEN_W-1:0]   TEN_LOAD = TEN_W'(TENURE - 1);

   chan_state_t       state_q, state_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic [TEN_W-1:0]  ten_q, ten_d;
   logic              req_q, req_d;
   logic              done_q, done_d;
   logic              w_dec;

   // Next-state, tenure countdown and pending bookkeeping
   always_comb begin
      state_d = state_q;
      ten_d   = ten_q;
      w_dec   = 1'b0;
      case (state_q)
         IDLE: if (pend_q != '0) state_d = REQ;
         REQ: begin
            if (i_gnt) begin
               state_d = OWN;
               ten_d   = TEN_LOAD;
            end
         end
         OWN: begin
            if (ten_q == '0) begin
               state_d = GAP;
               w_dec   = 1'b1;
            end else begin
               ten_d = ten_q - TEN_W'(1);
            end
         end
         GAP:     state_d = (pend_q != '0) ? REQ : IDLE;
         default: state_d = IDLE;
      endcase

      // A push coinciding with the tenure-end decrement is always accepted
      // (net zero); otherwise a push at the maximum count is dropped.
      pend_d = pend_q;
      if (w_dec && !i_push)
         pend_d = pend_q - PEND_W'(1);
      else if (!w_dec && i_push && (pend_q != PEND_MAX))
         pend_d = pend_q + PEND_W'(1);

      req_d  = (state_d == REQ) || (state_d == OWN);
      done_d = (state_d == OWN) && (ten_d == '0);
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pend_q  <= '0;
         ten_q   <= '0;
         req_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         ten_q   <= ten_d;
         req_q   <= req_d;
         done_q  <= done_d;
      end
   end

   assign o_req  = req_q;
   assign o_done = done_q;
   assign o_full = (pend_q == PEND_MAX);
   assign o_spur = i_gnt && ((state_q == IDLE) || (state_q == GAP));

`ifdef REQ_CLIENT_WATCHDOG_EN
   localparam int                WAIT_W   = wait_w(TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              timeout_q, timeout_d;

   // Count cycles spent waiting for a grant; flag once TIMEOUT is reached
   always_comb begin
      wait_d    = wait_q;
      timeout_d = timeout_q;
      if ((state_d == REQ) && (state_q != REQ))
         wait_d = '0;
      else if ((state_q == REQ) && (wait_q != WAIT_MAX))
         wait_d = wait_q + WAIT_W'(1);
      if ((state_d == REQ) && (wait_d == WAIT_MAX))
         timeout_d = 1'b1;
   end

   // Watchdog registers
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_timeout = timeout_q;
`else
   // TIMEOUT only matters when the watchdog is present.
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT > 0);
   assign o_timeout        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/req_client.sv
`default_nettype none
// ============================================================================
//  Module      : req_client
//  Description : Four-channel requester facing the `ctrl` arbiter. Maps the
//                scalar req/gnt ports onto channel instances and tracks
//                sticky grant-protocol errors. Optional grant watchdog is
//                compiled in with REQ_CLIENT_WATCHDOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module req_client
   import req_client_pkg::*;
#(
   parameter int PEND_W  = 3,
   parameter int TENURE  = 4,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NCHAN-1:0] push,
   output logic [NCHAN-1:0] full,
   input  logic             gnt_0,
   input  logic             gnt_1,
   input  logic             gnt_2,
   input  logic             gnt_3,
   output logic             req_0,
   output logic             req_1,
   output logic             req_2,
   output logic             req_3,
   output logic [NCHAN-1:0] done,
   output logic             err_spur,
   output logic             err_multi,
   output logic [NCHAN-1:0] timeout
);

   logic [NCHAN-1:0] w_gnt;
   logic [NCHAN-1:0] w_req;
   logic [NCHAN-1:0] w_spur;
   logic             err_spur_q, err_spur_d;
   logic             err_multi_q, err_multi_d;

   assign w_gnt = {gnt_3, gnt_2, gnt_1, gnt_0};
   assign req_0 = w_req[0];
   assign req_1 = w_req[1];
   assign req_2 = w_req[2];
   assign req_3 = w_req[3];

   for (genvar n = 0; n < NCHAN; n++) begin : g_chan
      req_client_chan #(
         .PEND_W  (PEND_W),
         .TENURE  (TENURE),
         .TIMEOUT (TIMEOUT)
      ) u_chan (
         .clk       (clk),
         .reset     (reset),
         .i_push    (push[n]),
         .i_gnt     (w_gnt[n]),
         .o_req     (w_req[n]),
         .o_full    (full[n]),
         .o_done    (done[n]),
         .o_spur    (w_spur[n]),
         .o_timeout (timeout[n])
      );
   end

   // Sticky protocol-error accumulation
   always_comb begin
      err_multi_d = err_multi_q || ($countones(w_gnt) > 1);
      err_spur_d  = err_spur_q || (|w_spur);
   end

   // Error flag registers
   always_ff @(posedge clk) begin
      if (reset) begin
         err_multi_q <= 1'b0;
         err_spur_q  <= 1'b0;
      end else begin
         err_multi_q <= err_multi_d;
         err_spur_q  <= err_spur_d;
      end
   end

   assign err_multi = err_multi_q;
   assign err_spur  = err_spur_q;

endmodule
`default_nettype wire

// File: tb/tb_req_client.sv
`default_nettype none
// ============================================================================
//  Module      : tb_req_client
//  Description : Scoreboard bench for req_client. A transaction-level model
//                (pending counts, ownership windows, sticky flags) predicts
//                outputs; expected done pulses are queued when a grant is
//                accepted and popped by an independent monitor.
//                Honours REQ_CLIENT_WATCHDOG_EN for the timeout output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_req_client;

   localparam int TEN  = 4;
   localparam int TMO  = 16;
   localparam int PMAX = 7;
`ifdef REQ_CLIENT_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] push_v;
   logic [3:0] gnt_v;
   wire  [3:0] req_v;
   wire  [3:0] full_v;
   wire  [3:0] done_v;
   wire  [3:0] tmo_v;
   wire        err_spur;
   wire        err_multi;

   req_client dut (
      .clk       (clk),
      .reset     (reset),
      .push      (push_v),
      .full      (full_v),
      .gnt_0     (gnt_v[0]),
      .gnt_1     (gnt_v[1]),
      .gnt_2     (gnt_v[2]),
      .gnt_3     (gnt_v[3]),
      .req_0     (req_v[0]),
      .req_1     (req_v[1]),
      .req_2     (req_v[2]),
      .req_3     (req_v[3]),
      .done      (done_v),
      .err_spur  (err_spur),
      .err_multi (err_multi),
      .timeout   (tmo_v)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ch;
      int cyc;
   } dexp_t;

   int    cyc = 0;
   int    pend_m[4];
   int    own_end[4];
   int    wait_start[4];
   bit    exp_req[4];
   bit    tmo_exp[4];
   bit    em_exp, es_exp;
   dexp_t dq[$];
   int    done_cnt[4];
   int    total = 0;
   int    bad   = 0;

   task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s ch%0d got=%0h want=%0h cycle=%0d", nm, n, act, exp, cyc);
      end
   endtask

   // Reference model: advances once per clock using the driven inputs only
   always @(posedge clk) begin
      bit nreq;
      int pold;
      dexp_t e;
      if (reset) begin
         for (int n = 0; n < 4; n++) begin
            pend_m[n] = 0; own_end[n] = -100; wait_start[n] = -1;
            exp_req[n] = 1'b0; tmo_exp[n] = 1'b0;
         end
         em_exp = 1'b0; es_exp = 1'b0;
         dq.delete();
      end else begin
         if ($countones(gnt_v) > 1) em_exp = 1'b1;
         for (int n = 0; n < 4; n++) begin
            pold = pend_m[n];
            if (gnt_v[n]) begin
               if (!exp_req[n]) es_exp = 1'b1;          // channel idle or in gap
               else if (cyc > own_end[n]) begin           // waiting: grant taken
                  own_end[n] = cyc + TEN;
                  e.ch = n; e.cyc = cyc + TEN;
                  dq.push_back(e);
                  wait_start[n] = -1;
               end
            end
            if (own_end[n] == cyc) pend_m[n]--;
            if (push_v[n] && pend_m[n] < PMAX) pend_m[n]++;
            if (own_end[n] >= cyc + 1)  nreq = 1'b1;     // owning
            else if (own_end[n] == cyc) nreq = 1'b0;     // one-cycle gap
            else if (exp_req[n])        nreq = 1'b1;     // no withdrawal
            else                        nreq = (pold > 0);
            if (nreq && !exp_req[n]) wait_start[n] = cyc + 1;
            if (nreq && own_end[n] < cyc + 1 && wait_start[n] >= 0 &&
                (cyc + 1 - wait_start[n]) == TMO)
               tmo_exp[n] = 1'b1;
            exp_req[n] = nreq;
         end
      end
      cyc++;
   end

   // Monitor: compares DUT outputs mid-cycle against model and done queue
   always @(negedge clk) begin
      bit    seen[4];
      dexp_t e;
      for (int n = 0; n < 4; n++) seen[n] = 1'b0;
      while (dq.size() > 0 && dq[0].cyc <= cyc) begin
         e = dq.pop_front();
         chk("done_pulse", e.ch, {31'd0, done_v[e.ch]}, 32'd1);
         seen[e.ch] = 1'b1;
      end
      for (int n = 0; n < 4; n++) begin
         if (!seen[n]) chk("done_quiet", n, {31'd0, done_v[n]}, 32'd0);
         if (done_v[n] === 1'b1) done_cnt[n]++;
         chk("req", n, {31'd0, req_v[n]}, {31'd0, exp_req[n]});
         chk("full", n, {31'd0, full_v[n]}, {31'd0, pend_m[n] == PMAX});
         chk("timeout", n, {31'd0, tmo_v[n]}, {31'd0, WD & tmo_exp[n]});
      end
      chk("err_multi", 0, {31'd0, err_multi}, {31'd0, em_exp});
      chk("err_spur", 0, {31'd0, err_spur}, {31'd0, es_exp});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit drained();
      bit d = 1'b1;
      for (int n = 0; n < 4; n++)
         if (pend_m[n] != 0 || exp_req[n] || own_end[n] >= cyc) d = 1'b0;
      return d;
   endfunction

   // Act as ctrl: grant at most one waiting channel, with probability 1/den
   task automatic grant_pick(input int den);
      int lst[4];
      int cnt = 0;
      gnt_v = 4'b0;
      for (int n = 0; n < 4; n++)
         if (exp_req[n] && own_end[n] < cyc) begin lst[cnt] = n; cnt++; end
      if (cnt > 0 && $urandom_range(den - 1) == 0)
         gnt_v[lst[$urandom_range(cnt - 1)]] = 1'b1;
   endtask

   task automatic serve(input int bound);
      int k = 0;
      while (!drained() && k < bound) begin
         grant_pick(1);
         tick();
         k++;
      end
      gnt_v = 4'b0;
      if (!drained()) begin
         total++; bad++;
         $display("FAIL drain: channels busy after %0d cycles", bound);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; tick(); reset = 1'b0;
   endtask

   initial begin
      int base;
      int k;
      reset = 1'b1; push_v = 4'b0; gnt_v = 4'b0;
      for (int n = 0; n < 4; n++) done_cnt[n] = 0;

      // Reset for two cycles, then quiet
      tick(); tick(); reset = 1'b0;
      repeat (20) tick();

      // Single transaction on ch0, grant five cycles after the push
      push_v = 4'b0001; tick(); push_v = 4'b0;
      repeat (4) tick();
      gnt_v = 4'b0001; tick(); gnt_v = 4'b0;
      repeat (10) tick();

      // Eight pushes on ch2: seventh fills, eighth dropped; then serve all
      base = done_cnt[2];
      for (int i = 0; i < 8; i++) begin
         push_v = 4'b0100; tick();
      end
      push_v = 4'b0;
      repeat (3) tick();
      serve(200);
      repeat (2) tick();
      chk("done_count", 2, done_cnt[2] - base, 32'd7);

      // Simultaneous grants on idle ch1/ch3, then lone spurious grant on ch0
      gnt_v = 4'b1010; tick(); gnt_v = 4'b0;
      repeat (3) tick();
      do_reset(); tick();
      gnt_v = 4'b0001; tick(); gnt_v = 4'b0;
      repeat (3) tick();

      // Starved request on ch1
      do_reset();
      push_v = 4'b0010; tick(); push_v = 4'b0;
      repeat (TMO + 8) tick();
      serve(100);

      // Reset during the second ownership cycle of ch0
      do_reset();
      push_v = 4'b0001; tick(); push_v = 4'b0;
      k = 0;
      while (!exp_req[0] && k < 10) begin tick(); k++; end
      if (!exp_req[0]) begin
         total++; bad++;
         $display("FAIL req_wait ch0: no request within 10 cycles");
      end
      gnt_v = 4'b0001; tick(); gnt_v = 4'b0;
      tick();
      reset = 1'b1; tick(); reset = 1'b0;
      repeat (8) tick();

      // Randomised traffic with a polite arbiter
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         for (int n = 0; n < 4; n++) push_v[n] = ($urandom_range(3) == 0);
         grant_pick(3);
         tick();
      end
      push_v = 4'b0;
      serve(600);
      repeat (3) tick();
      chk("queue_empty", 0, dq.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
